// File: rtl/zx_video_pkg.sv
// Shared ZX Spectrum video constants, fetch FSM states and colour/address helpers.
package zx_video_pkg;

    localparam logic [12:0] ZX_ATTR_BASE = 13'h1800;
    localparam int          ZX_H_ACTIVE  = 512;
    localparam int          ZX_V_ACTIVE  = 384;
    localparam logic [3:0]  LVL_NORMAL   = 4'hC;
    localparam logic [3:0]  LVL_BRIGHT   = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_BMP  = 2'd1,
        REQ_ATTR = 2'd2,
        READY    = 2'd3
    } fetch_state_t;

    function automatic logic [3:0] chan_level(input logic on, input logic bright);
        if (!on) begin
            return 4'h0;
        end else if (bright) begin
            return LVL_BRIGHT;
        end else begin
            return LVL_NORMAL;
        end
    endfunction

    // ZX colours are stored G,R,B; VGA wants R,G,B.
    function automatic logic [11:0] grb_to_rgb(input logic [2:0] grb, input logic bright);
        return {chan_level(grb[1], bright), chan_level(grb[2], bright), chan_level(grb[0], bright)};
    endfunction

    // The bitmap interleaves thirds, character rows and pixel lines.
    function automatic logic [12:0] bmp_addr(input logic [7:0] zy, input logic [4:0] col);
        return {zy[7:6], zy[2:0], zy[5:3], col};
    endfunction

    function automatic logic [12:0] attr_addr(input logic [7:0] zy, input logic [4:0] col);
        return ZX_ATTR_BASE + {3'b000, zy[7:3], col};
    endfunction

endpackage

// File: rtl/zx_attr_colour.sv
// Maps a ZX attribute byte and pixel bit to 12-bit RGB.
// Flash swap of ink/paper exists only when ZX_FLASH_EN is defined.
module zx_attr_colour
    import zx_video_pkg::*;
(
    input  logic [7:0]  attr,
    input  logic        pixel,
    input  logic        flash_phase,
    output logic [11:0] rgb
);

    logic       swap_s;
    logic [2:0] grb_s;

`ifdef ZX_FLASH_EN
    assign swap_s = attr[7] & flash_phase;
`else
    logic unused_s;
    assign unused_s = attr[7] ^ flash_phase;
    assign swap_s   = 1'b0;
`endif

    // Select ink or paper, honouring the flash swap
    always_comb begin
        grb_s = 3'b000;
        if (pixel ^ swap_s) begin
            grb_s = attr[2:0];
        end else begin
            grb_s = attr[5:3];
        end
        rgb = grb_to_rgb(grb_s, attr[6]);
    end

endmodule

// File: rtl/zx_pixel_renderer.sv
// ZX Spectrum screen to 2x-scaled VGA renderer with per-cell VRAM prefetch.
// Optional flash support is enabled by defining ZX_FLASH_EN.
module zx_pixel_renderer
    import zx_video_pkg::*;
#(
    parameter int H_OFFSET = 64,
    parameter int V_OFFSET = 48
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic [2:0]  border,
    output logic        mem_req,
    output logic [12:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        underrun,
    input  logic        underrun_clr
);

    localparam logic [9:0] X_FIRST     = 10'(H_OFFSET);
    localparam logic [9:0] X_END       = 10'(H_OFFSET + ZX_H_ACTIVE);
    localparam logic [9:0] X_FETCH     = 10'(H_OFFSET - 16);
    localparam logic [9:0] X_FETCH_END = 10'(H_OFFSET + ZX_H_ACTIVE - 16);
    localparam logic [9:0] Y_FIRST     = 10'(V_OFFSET);
    localparam logic [9:0] Y_END       = 10'(V_OFFSET + ZX_V_ACTIVE);

    fetch_state_t state_r;
    logic         mem_req_r;
    logic [12:0]  mem_addr_r;
    logic [4:0]   fetch_col_r;
    logic [7:0]   nxt_bmp_r;
    logic [7:0]   nxt_attr_r;
    logic         discard_r;
    logic         pend_r;
    logic [4:0]   pend_col_r;
    logic [7:0]   cur_bmp_r;
    logic [7:0]   cur_attr_r;
    logic         cur_bad_r;
    logic [11:0]  rgb_r;
    logic         underrun_r;

    logic [3:0]   px_lo_s;
    logic [4:0]   fetch_col_s;
    logic [7:0]   zy_s;
    logic         in_win_s;
    logic         in_y_s;
    logic         start_s;
    logic         load_s;
    logic         late_s;
    logic         relaunch_s;
    logic [4:0]   relaunch_col_s;
    logic [7:0]   cell_bmp_s;
    logic [7:0]   cell_attr_s;
    logic         cell_bad_s;
    logic         pixel_s;
    logic         flash_phase_s;
    logic [11:0]  cell_rgb_s;
    logic [11:0]  border_rgb_s;

    // Window decode, fetch start and load-point strobes
    always_comb begin
        px_lo_s        = 4'(hpos - X_FIRST);
        fetch_col_s    = 5'((hpos - X_FETCH) >> 4);
        zy_s           = 8'((vpos - Y_FIRST) >> 1);
        in_y_s         = (vpos >= Y_FIRST) && (vpos < Y_END);
        in_win_s       = in_y_s && (hpos >= X_FIRST) && (hpos < X_END);
        start_s        = in_y_s && (hpos >= X_FETCH) && (hpos < X_FETCH_END) && (px_lo_s == 4'd0);
        load_s         = in_win_s && (px_lo_s == 4'd0);
        late_s         = discard_r || load_s;
        relaunch_s     = start_s || pend_r;
        relaunch_col_s = start_s ? fetch_col_s : pend_col_r;
    end

    // Fetch sequencer; data arriving after its load point is dropped and
    // the queued column is launched on that same ack.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 13'h0000;
            fetch_col_r <= 5'd0;
            nxt_bmp_r   <= 8'h00;
            nxt_attr_r  <= 8'h00;
            discard_r   <= 1'b0;
            pend_r      <= 1'b0;
            pend_col_r  <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r     <= REQ_BMP;
                        mem_req_r   <= 1'b1;
                        mem_addr_r  <= bmp_addr(zy_s, fetch_col_s);
                        fetch_col_r <= fetch_col_s;
                    end
                end
                REQ_BMP, REQ_ATTR: begin
                    if (mem_ack && late_s) begin
                        discard_r <= 1'b0;
                        pend_r    <= 1'b0;
                        if (relaunch_s) begin
                            state_r     <= REQ_BMP;
                            mem_req_r   <= 1'b1;
                            mem_addr_r  <= bmp_addr(zy_s, relaunch_col_s);
                            fetch_col_r <= relaunch_col_s;
                        end else begin
                            state_r   <= IDLE;
                            mem_req_r <= 1'b0;
                        end
                    end else if (mem_ack && (state_r == REQ_BMP)) begin
                        nxt_bmp_r  <= mem_data;
                        state_r    <= REQ_ATTR;
                        mem_addr_r <= attr_addr(zy_s, fetch_col_r);
                    end else if (mem_ack) begin
                        nxt_attr_r <= mem_data;
                        state_r    <= READY;
                        mem_req_r  <= 1'b0;
                        pend_r     <= 1'b0;
                    end else begin
                        if (load_s) begin
                            discard_r <= 1'b1;
                        end
                        if (start_s) begin
                            pend_r     <= 1'b1;
                            pend_col_r <= fetch_col_s;
                        end
                    end
                end
                READY: begin
                    if (start_s) begin
                        state_r     <= REQ_BMP;
                        mem_req_r   <= 1'b1;
                        mem_addr_r  <= bmp_addr(zy_s, fetch_col_s);
                        fetch_col_r <= fetch_col_s;
                    end else if (load_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Current-cell registers advance at each load point
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            cur_bmp_r  <= 8'h00;
            cur_attr_r <= 8'h00;
            cur_bad_r  <= 1'b0;
        end else if (load_s) begin
            cur_bmp_r  <= nxt_bmp_r;
            cur_attr_r <= nxt_attr_r;
            cur_bad_r  <= (state_r != READY);
        end
    end

    // At the load point itself the new cell is rendered straight from the next-cell bytes
    always_comb begin
        if (load_s) begin
            cell_bmp_s  = nxt_bmp_r;
            cell_attr_s = nxt_attr_r;
            cell_bad_s  = (state_r != READY);
        end else begin
            cell_bmp_s  = cur_bmp_r;
            cell_attr_s = cur_attr_r;
            cell_bad_s  = cur_bad_r;
        end
        pixel_s      = cell_bmp_s[3'd7 - px_lo_s[3:1]];
        border_rgb_s = grb_to_rgb(border, 1'b0);
    end

`ifdef ZX_FLASH_EN
    logic [4:0] frame_cnt_r;

    // Frame counter for the flash phase
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            frame_cnt_r <= 5'd0;
        end else if ((hpos == 10'd0) && (vpos == 10'd0)) begin
            frame_cnt_r <= frame_cnt_r + 5'd1;
        end
    end

    assign flash_phase_s = frame_cnt_r[4];
`else
    assign flash_phase_s = 1'b0;
`endif

    zx_attr_colour u_attr_colour (
        .attr        (cell_attr_s),
        .pixel       (pixel_s),
        .flash_phase (flash_phase_s),
        .rgb         (cell_rgb_s)
    );

    // Registered pixel output
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            rgb_r <= 12'h000;
        end else if (!display_on) begin
            rgb_r <= 12'h000;
        end else if (in_win_s && !cell_bad_s) begin
            rgb_r <= cell_rgb_s;
        end else begin
            rgb_r <= border_rgb_s;
        end
    end

    // Sticky deadline-miss flag; a new miss beats a clear
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
        end else if (load_s && (state_r != READY)) begin
            underrun_r <= 1'b1;
        end else if (underrun_clr) begin
            underrun_r <= 1'b0;
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;
    assign red      = rgb_r[11:8];
    assign green    = rgb_r[7:4];
    assign blue     = rgb_r[3:0];
    assign underrun = underrun_r;

endmodule
